ahb_reg_slave: RTL

- AHB-Lite subordinate front end placed directly upstream of the word-addressed register file.
- Captures the AHB address phase and converts it into register-file controls (offset, write data, byte write-enables) during the data phase.
- Returns read data and OKAY/ERROR responses to the AHB fabric.
- The register file reads combinationally and writes on the clock edge; this block guarantees offset is stable for the whole data phase.

---
 rtl/ahb_reg_pkg.sv | 28 ++
 rtl/ahb_strobe_gen.sv | 28 ++
 rtl/ahb_reg_slave.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/ahb_reg_pkg.sv
// Shared AHB-Lite encodings and FSM states for the register-file slave.
// The AHB_REG_SLAVE_RDATA_REG_EN build uses ST_RDOUT for its registered read beat.
package ahb_reg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_e;

    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ,
        ST_ERR1,
        ST_ERR2,
        ST_RDOUT
    } state_e;

endpackage

// File: rtl/ahb_strobe_gen.sv
// Byte-lane strobe and alignment check for one AHB address phase.
module ahb_strobe_gen
    import ahb_reg_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  logic [2:0] hsize,
    output logic [3:0] strobe,
    output logic       misaligned
);

    always_comb begin
        strobe     = 4'b0000;
        misaligned = 1'b0;
        case (hsize)
            SIZE_BYTE: strobe = 4'b0001 << addr_lo;
            SIZE_HALF: begin
                strobe     = 4'b0011 << addr_lo;
                misaligned = addr_lo[0];
            end
            SIZE_WORD: begin
                strobe     = 4'b1111;
                misaligned = |addr_lo;
            end
            default:   misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/ahb_reg_slave.sv
// AHB-Lite front end for a word-addressed register file.
// Define AHB_REG_SLAVE_RDATA_REG_EN for a registered, two-cycle read.
module ahb_reg_slave
    import ahb_reg_pkg::*;
#(
    parameter  int NumWords    = 64,
    localparam int OffsetWidth = $clog2(NumWords)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   hsel,
    input  logic [31:0]            haddr,
    input  logic [1:0]             htrans,
    input  logic                   hwrite,
    input  logic [2:0]             hsize,
    input  logic [31:0]            hwdata,
    input  logic                   hready,
    output logic                   hreadyout,
    output logic                   hresp,
    output logic [31:0]            hrdata,
    output logic [OffsetWidth-1:0] offset,
    output logic [31:0]            wd,
    output logic [3:0]             we,
    input  logic [31:0]            rd
);

    state_e                 state_q, state_d;
    logic [OffsetWidth-1:0] offset_q, offset_d;
    logic [3:0]             strb_q, strb_d;
    logic [3:0]             strb;
    logic                   misaligned;
    logic                   sample;
    logic                   take;
    state_e                 ap_state;

    logic unused_bits;
    assign unused_bits = ^{haddr[31:OffsetWidth+2], htrans[0]};

    ahb_strobe_gen u_strobe (
        .addr_lo    (haddr[1:0]),
        .hsize      (hsize),
        .strobe     (strb),
        .misaligned (misaligned)
    );

    assign sample = hready & hsel & htrans[1];

    always_comb begin
        ap_state = ST_IDLE;
        if (misaligned) begin
            ap_state = ST_ERR1;
        end else if (hwrite) begin
            ap_state = ST_WRITE;
        end else begin
            ap_state = ST_READ;
        end
    end

    always_comb begin
        state_d   = state_q;
        offset_d  = offset_q;
        strb_d    = strb_q;
        hreadyout = 1'b1;
        hresp     = HRESP_OKAY;
        we        = 4'b0000;
        take      = 1'b0;
        case (state_q)
            ST_IDLE, ST_RDOUT: take = 1'b1;
            ST_WRITE: begin
                we   = strb_q;
                take = 1'b1;
            end
            ST_READ: begin
`ifdef AHB_REG_SLAVE_RDATA_REG_EN
                hreadyout = 1'b0;
                state_d   = ST_RDOUT;
`else
                take = 1'b1;
`endif
            end
            ST_ERR1: begin
                hreadyout = 1'b0;
                hresp     = HRESP_ERROR;
                state_d   = ST_ERR2;
            end
            ST_ERR2: begin
                hresp = HRESP_ERROR;
                take  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
        // Any ready data-phase beat may overlap the next address phase.
        if (take) begin
            state_d = sample ? ap_state : ST_IDLE;
            if (sample) begin
                offset_d = haddr[OffsetWidth+1:2];
                strb_d   = strb;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            offset_q <= '0;
            strb_q   <= 4'b0000;
        end else begin
            state_q  <= state_d;
            offset_q <= offset_d;
            strb_q   <= strb_d;
        end
    end

`ifdef AHB_REG_SLAVE_RDATA_REG_EN
    logic [31:0] hrdata_q, hrdata_d;

    always_comb begin
        hrdata_d = hrdata_q;
        if (state_q == ST_READ) begin
            hrdata_d = rd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hrdata_q <= 32'h0;
        end else begin
            hrdata_q <= hrdata_d;
        end
    end

    assign hrdata = hrdata_q;
`else
    assign hrdata = rd;
`endif

    assign offset = offset_q;
    assign wd     = hwdata;

endmodule
